// File: rtl/cpu_oci_monitor_ram.sv
// Debug-monitor RAM shared by the JTAG debug host and the CPU's Avalon-MM slave port.
// Holds at most one JTAG op. JTAG ops take priority over CPU accesses to the single-port RAM.
module cpu_oci_monitor_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_JRD,
        ST_CRD
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_q;

    logic              r_jop_valid;
    logic              r_jop_wr;
    logic [31:0]       r_jop_data;
    logic [ADDR_W-1:0] r_jaddr;
    logic [31:0]       r_mon_dreg;
    logic              r_ready;
    logic              r_error;

    logic              w_busy;
    logic              w_want_op;
    logic              w_want_wr;
    logic              w_addr_load;
    logic              w_clr;
    logic              w_accept;
    logic              w_drop;

    logic              w_mem_we;
    logic [3:0]        w_mem_be;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;
    logic              w_jop_done;
    logic              w_mon_load;

    logic              w_unused_jdo;
    assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign w_busy = r_jop_valid | (r_state != ST_IDLE);

    // Strobe decode: ocimem_a outranks ocimem_b, which outranks no_action.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_want_op   = 1'b0;
        w_want_wr   = 1'b0;
        w_addr_load = 1'b0;
        w_clr       = 1'b0;
        if (take_action_ocimem_a) begin
            w_clr       = jdo[35];
            w_want_op   = jdo[34];
            w_addr_load = ~(jdo[34] & w_busy);
        end else if (take_action_ocimem_b) begin
            w_want_op = 1'b1;
            w_want_wr = 1'b1;
        end else if (take_no_action_ocimem_a) begin
            w_want_op = 1'b1;
        end
    end

    assign w_accept = w_want_op & ~w_busy;
    assign w_drop   = w_want_op & w_busy;

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_be     = 4'b0000;
        w_mem_addr   = r_jaddr;
        w_mem_wdata  = r_jop_data;
        w_jop_done   = 1'b0;
        w_mon_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_jop_valid) begin
                    if (r_jop_wr) begin
                        w_mem_we   = 1'b1;
                        w_mem_be   = 4'b1111;
                        w_jop_done = 1'b1;
                    end else begin
                        w_state_next = ST_JRD;
                    end
                end else if (cpu_write) begin
                    w_mem_we    = 1'b1;
                    w_mem_be    = cpu_byteenable;
                    w_mem_addr  = cpu_address;
                    w_mem_wdata = cpu_writedata;
                end else if (cpu_read) begin
                    w_mem_addr   = cpu_address;
                    w_state_next = ST_CRD;
                end
            end
            ST_JRD: begin
                w_mon_load   = 1'b1;
                w_jop_done   = 1'b1;
                w_state_next = ST_IDLE;
            end
            ST_CRD:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: the RAM array is never reset so it can map onto block RAM; reset only blocks writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_mem_we && w_mem_be[i] && !reset)
                r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
        end
        r_q <= r_mem[w_mem_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_jop_valid <= 1'b0;
            r_jop_wr    <= 1'b0;
            r_jop_data  <= '0;
            r_jaddr     <= '0;
            r_mon_dreg  <= '0;
            r_ready     <= 1'b1;
            r_error     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_jop_valid <= 1'b1;
                r_jop_wr    <= w_want_wr;
                r_jop_data  <= jdo[34:3];
                r_ready     <= 1'b0;
            end else if (w_jop_done) begin
                r_jop_valid <= 1'b0;
                r_ready     <= 1'b1;
            end
            r_error <= (r_error & ~w_clr) | w_drop;
            // An explicit address load from the host beats the post-access increment.
            if (w_addr_load)     r_jaddr <= jdo[17 +: ADDR_W];
            else if (w_jop_done) r_jaddr <= r_jaddr + ADDR_W'(1);
            if (w_mon_load) r_mon_dreg <= r_q;
        end
    end

    assign MonDReg         = r_mon_dreg;
    assign monitor_ready   = r_ready;
    assign monitor_error   = r_error;
    assign cpu_readdata    = (r_state == ST_CRD) ? r_q : 32'h0;
    assign cpu_waitrequest = (cpu_read | cpu_write)
                           & ~((r_state == ST_IDLE) & ~r_jop_valid & cpu_write)
                           & ~(r_state == ST_CRD);

endmodule

// File: tb/tb_cpu_oci_monitor_ram.sv
// Scoreboard bench for cpu_oci_monitor_ram: stimulus pushes expectations, a negedge monitor
// pops them on each monitor_ready rise (JTAG) or each completed CPU transfer.
module tb_cpu_oci_monitor_ram;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [7:0]  cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_writedata = '0;
    logic [3:0]  cpu_byteenable = '0;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
        logic [7:0]  waits;
    } cpu_exp_t;

    logic [31:0] jtag_q[$];
    cpu_exp_t    cpu_q[$];
    logic [31:0] exp_mon = '0;
    logic        skip_rise = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    cpu_oci_monitor_ram #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic cpu_exp_t mk_cpu(input logic is_read, input logic [31:0] d, input int w);
        cpu_exp_t e;
        e.is_read = is_read;
        e.data    = d;
        e.waits   = w[7:0];
        return e;
    endfunction

    function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic [7:0] addr);
        logic [37:0] v;
        v = '0;
        v[35] = clr;
        v[34] = rd;
        v[24:17] = addr;
        return v;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    // Monitor: JTAG completions on monitor_ready rising, CPU completions on waitrequest low.
    initial begin : monitor
        logic prev_ready;
        int   waits;
        cpu_exp_t e;
        prev_ready = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (prev_ready === 1'b0 && monitor_ready === 1'b1) begin
                if (skip_rise) begin
                    skip_rise = 1'b0;
                end else if (jtag_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL jtag_unexpected: got ready rise, required none");
                end else begin
                    check("jtag_mondreg", MonDReg, jtag_q.pop_front());
                end
            end
            prev_ready = monitor_ready;
            if ((cpu_read || cpu_write) && cpu_waitrequest === 1'b1) begin
                waits++;
            end else if ((cpu_read || cpu_write) && cpu_waitrequest === 1'b0) begin
                if (cpu_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL cpu_unexpected: got completed transfer, required none");
                end else begin
                    e = cpu_q.pop_front();
                    check("cpu_waits", waits, {24'h0, e.waits});
                    if (e.is_read) check("cpu_readdata", cpu_readdata, e.data);
                end
                waits = 0;
            end
        end
    end

    task automatic wait_cpu_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_waitrequest && n < 20);
        if (cpu_waitrequest) check("cpu_timeout", 32'd1, 32'd0);
    endtask

    task automatic cpu_rd(input logic [7:0] a, input logic [31:0] exp, input int waits);
        cpu_q.push_back(mk_cpu(1'b1, exp, waits));
        @(posedge clk); #1;
        cpu_address = a;
        cpu_read = 1'b1;
        wait_cpu_done();
        @(posedge clk); #1;
        cpu_read = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        cpu_q.push_back(mk_cpu(1'b0, 32'h0, 0));
        @(posedge clk); #1;
        cpu_address = a;
        cpu_writedata = d;
        cpu_byteenable = be;
        cpu_write = 1'b1;
        wait_cpu_done();
        @(posedge clk); #1;
        cpu_write = 1'b0;
    endtask

    // which: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action. Returns one cycle after the strobe.
    task automatic strobe(input int which, input logic [37:0] d);
        @(posedge clk); #1;
        jdo = d;
        take_action_ocimem_a    = (which == 0);
        take_action_ocimem_b    = (which == 1);
        take_no_action_ocimem_a = (which == 2);
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic set_addr(input logic [7:0] a);
        strobe(0, jdo_a(1'b0, 1'b0, a));
        @(negedge clk);
        check("addr_ready", monitor_ready, 1'b1);
    endtask

    task automatic jtag_write(input logic [31:0] d);
        jtag_q.push_back(exp_mon);
        strobe(1, jdo_b(d));
        @(negedge clk);
        check("wr_ready_n1", monitor_ready, 1'b0);
        @(negedge clk);
        check("wr_ready_n2", monitor_ready, 1'b1);
    endtask

    task automatic jtag_read(input int which, input logic [7:0] a, input logic [31:0] exp);
        exp_mon = exp;
        jtag_q.push_back(exp);
        strobe(which, jdo_a(1'b0, 1'b1, a));
        @(negedge clk);
        check("rd_ready_n1", monitor_ready, 1'b0);
        @(negedge clk);
        check("rd_ready_n2", monitor_ready, 1'b0);
        @(negedge clk);
        check("rd_ready_n3", monitor_ready, 1'b1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready", monitor_ready, 1'b1);
        check("rst_error", monitor_error, 1'b0);
        check("rst_waitreq", cpu_waitrequest, 1'b0);
        check("rst_readdata", cpu_readdata, 32'h0);

        // Sequential JTAG writes and reads around 0x10.
        set_addr(8'h10);
        jtag_write(32'hDEADBEEF);
        jtag_write(32'h12345678);
        jtag_read(0, 8'h10, 32'hDEADBEEF);
        jtag_read(2, 8'h00, 32'h12345678);
        // jaddr must now be 0x12: the next write lands there.
        jtag_write(32'h0BADF00D);
        cpu_rd(8'h12, 32'h0BADF00D, 1);

        // Address wrap at the top of the RAM.
        set_addr(8'hFF);
        jtag_write(32'hCAFEF00D);
        jtag_write(32'h11112222);
        cpu_rd(8'hFF, 32'hCAFEF00D, 1);
        cpu_rd(8'h00, 32'h11112222, 1);

        // CPU byte-enabled write over a zeroed word.
        set_addr(8'h03);
        jtag_write(32'h0);
        cpu_wr(8'h03, 32'hAABBCCDD, 4'b0101);
        cpu_rd(8'h03, 32'h00BB00DD, 1);

        // Back-to-back writes: the second is dropped and flags an error.
        set_addr(8'h21);
        jtag_write(32'h55555555);
        set_addr(8'h20);
        jtag_q.push_back(exp_mon);
        @(posedge clk); #1;
        jdo = jdo_b(32'hA0A0A0A0);
        take_action_ocimem_b = 1'b1;
        @(posedge clk); #1;
        jdo = jdo_b(32'hB0B0B0B0);
        @(posedge clk); #1;
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        check("drop_error", monitor_error, 1'b1);
        check("drop_ready", monitor_ready, 1'b1);
        cpu_rd(8'h20, 32'hA0A0A0A0, 1);
        cpu_rd(8'h21, 32'h55555555, 1);
        @(posedge clk); #1;
        jdo = jdo_a(1'b1, 1'b0, 8'h40);
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        check("clr_same_cycle", monitor_error, 1'b1);
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        @(negedge clk);
        check("clr_next_cycle", monitor_error, 1'b0);

        // CPU read arrives while a JTAG read is pending: JTAG first, 3 wait cycles.
        exp_mon = 32'hDEADBEEF;
        jtag_q.push_back(exp_mon);
        cpu_q.push_back(mk_cpu(1'b1, 32'h00BB00DD, 3));
        @(posedge clk); #1;
        jdo = jdo_a(1'b0, 1'b1, 8'h10);
        take_action_ocimem_a = 1'b1;
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        cpu_address = 8'h03;
        cpu_read = 1'b1;
        wait_cpu_done();
        @(posedge clk); #1;
        cpu_read = 1'b0;

        // Reset lands in JRD: access aborted, registers cleared, RAM kept.
        skip_rise = 1'b1;
        strobe(0, jdo_a(1'b0, 1'b1, 8'h11));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("jrd_ready_low", monitor_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", monitor_ready, 1'b1);
        check("abort_mondreg", MonDReg, 32'h0);
        check("abort_error", monitor_error, 1'b0);
        exp_mon = 32'h0;
        jtag_read(0, 8'h11, 32'h12345678);
        cpu_rd(8'h20, 32'hA0A0A0A0, 1);

        repeat (5) @(posedge clk);
        check("jtag_q_drained", jtag_q.size(), 32'd0);
        check("cpu_q_drained", cpu_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_oci_monitor_ram.md
# cpu_oci_monitor_ram

Debug-monitor RAM and access engine that consumes the clk-domain command strobes and `jdo` payload produced by the CPU JTAG debug module, and returns `MonDReg`, `monitor_ready` and `monitor_error` to it. It holds a single-port 32-bit debug RAM, shared between the JTAG host (monitor accesses) and the CPU (Avalon-MM slave, debug ROM/RAM window). JTAG accesses take priority over the CPU.

## Interface
- `ADDR_W`, 8: word-address width of the debug RAM (depth 2^ADDR_W, legal 4..16).
- `clk`  in  1  system clock; sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  JTAG payload, already in the clk domain.
- `take_action_ocimem_a`  in  1  strobe: load address = `jdo[17+ADDR_W-1:17]`; `jdo[35]` = clear error; `jdo[34]` = queue read at the new address.
- `take_no_action_ocimem_a`  in  1  strobe: queue read at the current address.
- `take_action_ocimem_b`  in  1  strobe: queue write of `jdo[34:3]` at the current address.
- `MonDReg`  out  32  last JTAG read data.
- `monitor_ready`  out  1  1 = no JTAG op pending.
- `monitor_error`  out  1  sticky: a JTAG op was dropped because one was already pending.
- `cpu_address`  in  ADDR_W  CPU word address.
- `cpu_read`, `cpu_write`  in  1  Avalon-MM request, held until `cpu_waitrequest` = 0.
- `cpu_writedata`  in  32.
- `cpu_byteenable`  in  4.
- `cpu_readdata`  out  32  valid in the cycle `cpu_waitrequest` = 0 for a read.
- `cpu_waitrequest`  out  1  combinational.

## Operation
- Pending JTAG op register: `jop_valid`, type (RD/WR), data. Address register `jaddr` (ADDR_W).
- Strobe priority when more than one fires in a cycle (illegal upstream): `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority strobes are ignored without error.
- Any strobe that would queue an op while `jop_valid` = 1 or FSM ≠ IDLE: op dropped, `monitor_error` <= 1, `jaddr` unchanged.
  - `take_action_ocimem_a` with only the clear bit (`jdo[35]` = 1, `jdo[34]` = 0) is always accepted.
  - Its address load is suppressed only when it also requests a read while busy.
- Clear (`jdo[35]`) takes effect the same cycle as its strobe. If the same strobe is also dropped, the error sets again (set wins).
- Accepting a queued op sets `monitor_ready` <= 0.
- FSM states:
  - IDLE:
    - `jop_valid` WR: write the full word at `jaddr`; `jaddr` += 1; `jop_valid` <= 0; `monitor_ready` <= 1; stay in IDLE.
    - `jop_valid` RD: issue read at `jaddr`; go to JRD.
    - Otherwise `cpu_write`: byte-enabled write; stay in IDLE.
    - Otherwise `cpu_read`: issue read; go to CRD.
  - JRD: `MonDReg` <= RAM q; `jaddr` += 1; `jop_valid` <= 0; `monitor_ready` <= 1; go to IDLE.
  - CRD: `cpu_readdata` = RAM q; go to IDLE.
- `cpu_waitrequest` = (`cpu_read` | `cpu_write`) & ~(IDLE & ~`jop_valid` & `cpu_write`) & ~CRD.
- `jaddr` wraps modulo 2^ADDR_W (all-ones + 1 -> 0). There is no error on wrap.
- `cpu_read` and `cpu_write` both high: write served, read ignored (master violation).
- Reset:
  - `MonDReg` = 0, `monitor_ready` = 1, `monitor_error` = 0, `jaddr` = 0, `jop_valid` = 0, FSM = IDLE, `cpu_readdata` = 0.
  - RAM contents are preserved.
  - A reset during JRD/CRD aborts that access; the CPU master re-sees `cpu_waitrequest` per the equation above.

## Timing
- RAM: synchronous read, 1-cycle latency.
- JTAG write, strobe in cycle N: `jop_valid` from N+1; RAM written at the end of N+1; `monitor_ready` = 1 from N+2.
- JTAG read, strobe in cycle N: issued N+1, JRD in N+2; `MonDReg` valid and `monitor_ready` = 1 from N+3.
- A CPU read in progress (CRD) delays a newly pending JTAG op by 1 cycle. A CPU op never delays by more.
- CPU write, no JTAG pending: 0 wait states. CPU read: 1 wait state (`cpu_waitrequest` low in CRD).
- CPU stall while JTAG pending: 1 cycle (WR) or 2 cycles (RD).

## Test plan
- Reset, then ocimem_a with addr 0x10 and `jdo[34]` = 0, then ocimem_b data 0xDEADBEEF, then ocimem_b data 0x12345678 -> RAM[0x10] = 0xDEADBEEF, RAM[0x11] = 0x12345678, `jaddr` = 0x12, `monitor_ready` high by N+2 after each write.
- ocimem_a with addr 0x10 and `jdo[34]` = 1 -> `MonDReg` = 0xDEADBEEF at N+3; `take_no_action_ocimem_a` -> `MonDReg` = 0x12345678, `jaddr` = 0x12.
- ocimem_b at `jaddr` = 0xFF, ADDR_W = 8 -> written at 0xFF, `jaddr` = 0x00.
- Two ocimem_b strobes 1 cycle apart -> second dropped, `monitor_error` = 1, RAM unchanged at `jaddr`+1. ocimem_a with `jdo[35]` = 1 -> error clears next cycle.
- CPU write 0xAABBCCDD with byteenable 4'b0101 to addr 3 (old 0) -> word = 0x00BB00DD, 0 wait states. CPU read addr 3 -> 0x00BB00DD after 1 wait.
- CPU read held while a JTAG read is queued the same cycle -> JTAG served first, CPU `cpu_waitrequest` high 3 cycles, correct data. Assert `reset` during JRD -> `monitor_ready` = 1, `MonDReg` = 0, RAM intact.
